rr_priority_arbiter: RTL
========================

Name: rr_priority_arbiter

Overview:
- Parametrised N-way arbiter, successor to the 4-bit fixed-priority arbiter.
- Run-time mode selects fixed-priority or round-robin arbitration.
- A granted requester keeps its grant while it holds its request, up to MAX_HOLD consecutive cycles; after that the arbiter is forced to re-arbitrate.
- Registered one-hot grant plus encoded index; sits in front of shared resources such as a memory port or bus.

Parameters:
- N, 4, number of requesters (N >= 2).
- MAX_HOLD, 4, maximum consecutive cycles one grant is held (>= 1; 1 = re-arbitrate every cycle).
- IDW, $clog2(N), width of gnt_id.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  N  request vector; bit i = requester i.
- mode  input  1  0 = fixed priority (bit 0 highest), 1 = round-robin.
- gnt  output  N  registered one-hot grant, or all zero.
- gnt_id  output  IDW  index of granted requester; 0 when gnt_valid=0.
- gnt_valid  output  1  high when any grant is active.

Behaviour:
- Reset (rst=0, asynchronous, no clock required):
  - gnt=0, gnt_id=0, gnt_valid=0.
  - Round-robin pointer ptr=0, hold counter hold_cnt=0.
  - Takes effect immediately, including mid-grant.
  - First arbitration happens on the first rising edge after rst returns high.
- Latency: req is sampled at a rising edge; the resulting grant is visible after that edge (1 cycle). Outputs are registered only; there is no combinational req->gnt path.
- Per rising edge, state machine IDLE / GRANT:
  - IDLE (gnt_valid=0): if req==0, stay IDLE. Otherwise arbitrate and go to GRANT with hold_cnt=0.
  - GRANT, owner k, hold: if req[k]=1 and hold_cnt < MAX_HOLD-1, keep gnt unchanged and increment hold_cnt.
  - GRANT, release: if req[k]=0, arbitrate over the current req (k is not masked). If req==0, go to IDLE with gnt=0 on that edge.
  - GRANT, expiry: if req[k]=1 and hold_cnt == MAX_HOLD-1, re-arbitrate with req[k] masked whenever any other bit of req is set.
    - If k is the sole requester, regrant k with hold_cnt=0. gnt does not glitch and no idle cycle is inserted.
- Arbitration:
  - Fixed mode: the lowest-index set bit wins.
  - Round-robin mode: search upward from ptr with wrap-around (ptr, ptr+1, ..., N-1, 0, ..., ptr-1); the first set bit wins.
  - On every new grant to index w (both modes), ptr <= (w+1) mod N. When w=N-1, ptr wraps to 0.
  - A regrant to the same owner after expiry (sole requester) also updates ptr.
- A mode change never breaks a held grant; it applies at the next arbitration.
- gnt is always one-hot or zero. gnt_id is the binary encoding of gnt. gnt_valid = |gnt.
- req bits for a requester that is not granted may toggle freely; there is no request queueing.
- hold_cnt width is $clog2(MAX_HOLD)+1. It saturates by construction and never wraps.

Test Plan:
- Reset: N=4, mode=1, req=1111, 3 grants issued, then rst=0 between edges -> gnt=0000, gnt_valid=0 immediately. After release the first grant is 0001 (ptr=0).
- Fixed hold/expiry: mode=0, MAX_HOLD=4, req=0101 held -> gnt=0001 for 4 cycles, then 0100 for 4 cycles, then 0001, alternating. gnt_id 0/2 accordingly.
- Round-robin rotation: mode=1, MAX_HOLD=1, req=1111 held -> gnt 0001, 0010, 0100, 1000, 0001 (wrap). gnt_id 0, 1, 2, 3, 0.
- Release and pointer: mode=1 from reset, req=1010 -> gnt=0010 (id 1), ptr=2. Drop req[1] -> next edge gnt=1000 (id 3), ptr=0.
- Sole requester: mode=0, MAX_HOLD=4, req=0100 for 12 cycles -> gnt=0100 every cycle with no gap; hold_cnt cycles 0..3 three times.
- Idle and latency: from a grant, req drops to 0000 -> gnt=0000, gnt_valid=0 on the next edge. Then req=1000 -> gnt=1000 exactly one edge later, in both modes.

Source files
------------

// File: rtl/rr_priority_arbiter.sv
// rr_priority_arbiter
//   N-way request arbiter. Arbitration is fixed priority or round-robin,
//   chosen at run time. A granted requester may hold its grant for up to
//   MAX_HOLD consecutive cycles. After that, arbitration is forced again.
//   All outputs are registered, so a grant appears one cycle after req is
//   sampled.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   req[N]     request vector, bit i = requester i
//   mode       0 = fixed priority (bit 0 highest), 1 = round-robin
//   gnt[N]     registered one-hot grant, or all zero
//   gnt_id     binary index of the granted requester, 0 when idle
//   gnt_valid  high while any grant is active
module rr_priority_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           mode,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid
);

  // Hold counter counts 0..MAX_HOLD-1 and never needs to wrap.
  localparam int unsigned HW = $clog2(MAX_HOLD) + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Return the index of the lowest set bit of v, or 0 if v is empty.
  function automatic logic [IDW-1:0] lowest_idx(input logic [N-1:0] v);
    logic [IDW-1:0] idx;
    idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (v[i]) idx = IDW'(i);
    end
    return idx;
  endfunction

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] id_q, id_d;
  logic           valid_q, valid_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HW-1:0]  hold_q, hold_d;

  logic           owner_req;
  logic           hold_ok;
  logic [N-1:0]   others;
  logic [N-1:0]   arb_req;
  logic [N-1:0]   hi_mask;
  logic [N-1:0]   req_hi;
  logic [IDW-1:0] fix_idx;
  logic [IDW-1:0] rr_idx;
  logic [IDW-1:0] win_idx;
  logic [N-1:0]   win_onehot;
  logic [IDW-1:0] win_ptr;
  logic           arb_any;

  // The owner still requests, and it has not used up its hold budget.
  assign owner_req = |(req & gnt_q);
  assign hold_ok   = (hold_q < HW'(MAX_HOLD - 1));
  assign others    = req & ~gnt_q;

  // Arbitration input. On hold expiry the owner is masked, but only when
  // another requester is waiting. A sole requester is simply regranted.
  always_comb begin
    arb_req = req;
    if (state_q == ST_GRANT && owner_req && !hold_ok && (|others)) begin
      arb_req = others;
    end
  end

  // Round-robin search from ptr with wrap-around. First look at bits at or
  // above ptr. If none is set, the lowest set bit overall wins.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < int'(N); i++) begin
      hi_mask[i] = (IDW'(i) >= ptr_q);
    end
  end

  assign req_hi  = arb_req & hi_mask;
  assign fix_idx = lowest_idx(arb_req);
  assign rr_idx  = (|req_hi) ? lowest_idx(req_hi) : fix_idx;
  assign win_idx = mode ? rr_idx : fix_idx;
  assign arb_any = |arb_req;

  assign win_onehot = {{(N-1){1'b0}}, 1'b1} << win_idx;
  assign win_ptr    = (win_idx == IDW'(N - 1)) ? '0 : win_idx + IDW'(1);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic: hold, release, expiry and idle handling.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;

    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          state_d = ST_GRANT;
          gnt_d   = win_onehot;
          id_d    = win_idx;
          valid_d = 1'b1;
          ptr_d   = win_ptr;
          hold_d  = '0;
        end
      end

      ST_GRANT: begin
        if (owner_req && hold_ok) begin
          // Owner keeps the grant; the grant outputs stay the same.
          hold_d = hold_q + HW'(1);
        end else if (arb_any) begin
          // Release or expiry: a new grant. This may be the same owner.
          gnt_d   = win_onehot;
          id_d    = win_idx;
          valid_d = 1'b1;
          ptr_d   = win_ptr;
          hold_d  = '0;
        end else begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          id_d    = '0;
          valid_d = 1'b0;
          hold_d  = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        id_d    = '0;
        valid_d = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  assign gnt       = gnt_q;
  assign gnt_id    = id_q;
  assign gnt_valid = valid_q;

endmodule
